game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Top-level game sequencer for the dino VGA game. Owns IDLE/RUN/HIT/OVER/RESTART
//  flow: freezes play on collision, flashes the dino, then drives overlay_en to
//  gate (and blink) the GAME OVER text overlay. Re-arms on a fresh button press.
//  Sits beside the VGA sync and sprite logic and advances only on frame_tick.
// PARAMETERS
//  HIT_FRAMES      30  frames frozen with flash before the overlay appears (>=1)
//  BLINK_FRAMES    20  frames per overlay on/off half-period (>=1)
//  LOCKOUT_FRAMES  60  frames in OVER before a restart press is accepted (>=0)
//  CNT_W            8  frame counter width; every *_FRAMES value must be < 2**CNT_W
// PORTS
//  clk         in   1  pixel clock; the only clock
//  reset       in   1  asynchronous, active-high; clears all state
//  frame_tick  in   1  1-cycle pulse, once per frame (start of vblank)
//  collision   in   1  level; dino/obstacle overlap this frame
//  btn         in   1  jump/start button, already synchronised to clk, level
//  run_en      out  1  1 = world scrolls, score counts
//  freeze      out  1  1 = sprites hold position (HIT and OVER)
//  flash       out  1  dino blank strobe, meaningful only in HIT
//  overlay_en  out  1  AND-gated with the gameover text pixel by the mixer
//  restart     out  1  1-cycle pulse: clear score, obstacles, dino position
//  state_o     out  3  current state code, for debug/LEDs
// BEHAVIOUR
//  Reset: state=IDLE; run_en=freeze=flash=overlay_en=restart=0; cnt=0; armed=0;
//   btn_q=1 so a button held through reset produces no press.
//  press = btn & ~btn_q (btn_q registered every clk). One press per rising edge.
//  All outputs are registered or decoded from registered state. No combinational
//   input->output path.
//  IDLE:    outputs 0. On press -> RESTART.
//  RESTART: restart=1 for exactly one cycle, then -> RUN. cnt cleared.
//  RUN:     run_en=1. collision=1 on any cycle -> HIT next cycle; cnt=0.
//           In RUN, collision is sampled every clk, not only on frame_tick.
//  HIT:     freeze=1, run_en=0, flash=cnt[2]. cnt++ on frame_tick.
//           When the tick that makes cnt==HIT_FRAMES arrives -> OVER next cycle.
//           cnt=0, overlay_en=1, armed=0.
//  OVER:    freeze=1. cnt++ on each frame_tick, saturating at 2**CNT_W-1.
//           overlay_en toggles on every BLINK_FRAMES-th tick, counted by a separate
//           blink counter. Starts at 1 on entry.
//           armed sets on the first cycle with cnt>=LOCKOUT_FRAMES and btn==0.
//           press && armed -> RESTART; overlay_en=0 on exit.
//  Collision is ignored outside RUN. Button is ignored in RUN, HIT and RESTART.
//  Simultaneous: frame_tick+collision in RUN -> collision wins, goes to HIT, cnt=0.
//   In OVER, press on the same cycle armed would set does not restart; armed
//   must already be 1.
//  Button held from RUN through OVER: no restart until it is released after lockout
//   and pressed again.
//  Reset mid-operation (any state, any cycle): immediate return to reset values.
//   A pending restart pulse is dropped.
//  Illegal state code: -> IDLE next cycle, outputs 0.
// STRUCTURE
//  game_defs.vh (shared include): state codes ST_IDLE=0, ST_RUN=1, ST_HIT=2,
//   ST_OVER=3, ST_RESTART=4; default frame constants. The mixer and LED debug
//   decode reuse these codes.
//  Sub-module btn_edge: btn_q register plus the press pulse. Reset drives btn_q to 1.
//  Everything else stays inline: the FSM, the frame counter and the blink counter.
// TESTING
//  T1 reset, btn pulse -> restart high exactly 1 clk, then state_o=1, run_en=1.
//  T2 RUN, collision 1 clk -> next clk state_o=2, freeze=1, run_en=0.
//   After 30 ticks -> state_o=3, overlay_en=1.
//  T3 OVER, BLINK_FRAMES=20 -> overlay_en toggles at ticks 20,40,60.
//   Exactly 3 toggles in 60 ticks.
//  T4 btn held from RUN into OVER, released at tick 10, pressed at tick 30 -> no
//   restart. Release at tick 61, press -> restart pulse, overlay_en=0.
//  T5 btn held through reset release -> no restart. collision in IDLE/OVER -> no
//   state change.
//  T6 reset asserted mid-HIT (cnt=15) -> same-cycle outputs 0, state_o=0.
//   Assertion: restart never high 2 consecutive clks.

Source files
------------

// File: rtl/game_state_ctrl_pkg.sv
// Shared state codes and default frame constants for the dino game sequencer.
// The mixer and LED debug decode rely on these exact state encodings.
package game_state_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_HIT     = 3'd2,
        ST_OVER    = 3'd3,
        ST_RESTART = 3'd4
    } state_e;

    localparam int HIT_FRAMES_DEF     = 30;
    localparam int BLINK_FRAMES_DEF   = 20;
    localparam int LOCKOUT_FRAMES_DEF = 60;
    localparam int CNT_W_DEF          = 8;

    function automatic logic is_frozen(input state_e s);
        return (s == ST_HIT) || (s == ST_OVER);
    endfunction

endpackage

// File: rtl/game_state_ctrl_btn_edge.sv
// Button rising-edge detector. btn_q resets high so a button already held
// when reset releases is not mistaken for a fresh press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic btn_q;
    logic btn_d;

    always_comb begin
        btn_d = btn;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_q <= 1'b1;
        else       btn_q <= btn_d;
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow sequencer: IDLE -> RESTART -> RUN -> HIT -> OVER -> RESTART.
// Frame-paced counters drive the hit flash, overlay blink and restart lockout.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int HIT_FRAMES     = HIT_FRAMES_DEF,
    parameter int BLINK_FRAMES   = BLINK_FRAMES_DEF,
    parameter int LOCKOUT_FRAMES = LOCKOUT_FRAMES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       collision,
    input  logic       btn,
    output logic       run_en,
    output logic       freeze,
    output logic       flash,
    output logic       overlay_en,
    output logic       restart,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] LOCK_CNT   = CNT_W'(LOCKOUT_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [CNT_W-1:0]   blink_q,   blink_d;
    logic               armed_q,   armed_d;
    logic               overlay_q, overlay_d;
    logic               press;

    btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blink_d   = blink_q;
        armed_d   = armed_q;
        overlay_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                blink_d = '0;
                armed_d = 1'b0;
                if (press) state_d = ST_RESTART;
            end

            ST_RESTART: begin
                cnt_d   = '0;
                blink_d = '0;
                armed_d = 1'b0;
                state_d = ST_RUN;
            end

            // Collision is a level sampled every clk so a one-cycle overlap
            // between ticks is never missed.
            ST_RUN: begin
                if (collision) begin
                    state_d = ST_HIT;
                    cnt_d   = '0;
                end
            end

            ST_HIT: begin
                if (frame_tick) begin
                    if (cnt_q == HIT_LAST) begin
                        state_d   = ST_OVER;
                        cnt_d     = '0;
                        blink_d   = '0;
                        armed_d   = 1'b0;
                        overlay_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_OVER: begin
                overlay_d = overlay_q;
                if (frame_tick) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (blink_q == BLINK_LAST) begin
                        blink_d   = '0;
                        overlay_d = ~overlay_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
                // Arming needs a released button after lockout, so a button held
                // since RUN must be let go and pressed again.
                if (!armed_q && (cnt_q >= LOCK_CNT) && !btn) armed_d = 1'b1;
                if (press && armed_q) begin
                    state_d   = ST_RESTART;
                    cnt_d     = '0;
                    blink_d   = '0;
                    armed_d   = 1'b0;
                    overlay_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                blink_d = '0;
                armed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            blink_q   <= '0;
            armed_q   <= 1'b0;
            overlay_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            armed_q   <= armed_d;
            overlay_q <= overlay_d;
        end
    end

    // Every output decodes registered state only.
    assign run_en     = (state_q == ST_RUN);
    assign freeze     = is_frozen(state_q);
    assign flash      = (state_q == ST_HIT) && cnt_q[2];
    assign overlay_en = overlay_q;
    assign restart    = (state_q == ST_RESTART);
    assign state_o    = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: vector table for the basic flow, then
// hand-written sequences for hit timing, blink, lockout and reset corners.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, collision, btn;
    logic       run_en, freeze, flash, overlay_en, restart;
    logic [2:0] state_o;

    int passed = 0;
    int total  = 0;
    int restart_seen = 0;
    logic prev_rs = 1'b0;

    game_state_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .collision  (collision),
        .btn        (btn),
        .run_en     (run_en),
        .freeze     (freeze),
        .flash      (flash),
        .overlay_en (overlay_en),
        .restart    (restart),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // restart must never stay high on two consecutive clocks
    always @(negedge clk) begin
        if (restart && prev_rs) begin
            total++;
            $display("FAIL restart_double: got two consecutive restart cycles, want one");
        end
        prev_rs = restart;
    end

    typedef struct {
        logic       tick;
        logic       col;
        logic       b;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [7:0] ex(input int st, input bit run, input bit frz,
                                      input bit fl, input bit ov, input bit rs);
        return {3'(st), run, frz, fl, ov, rs};
    endfunction

    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {state_o, run_en, freeze, flash, overlay_en, restart};
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got st/run/frz/fl/ov/rs=%b want %b", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic step(input logic t, input logic c, input logic b);
        frame_tick = t;
        collision  = c;
        btn        = b;
        @(posedge clk);
        #1;
        if (restart) restart_seen++;
    endtask

    task automatic do_tick(input logic b);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
    endtask

    initial begin
        int toggles;
        int rs_base;
        logic prev_ov;

        vecs[0]  = '{0, 0, 0, ex(0, 0, 0, 0, 0, 0), "idle"};
        vecs[1]  = '{0, 1, 0, ex(0, 0, 0, 0, 0, 0), "idle_collision_ignored"};
        vecs[2]  = '{0, 0, 1, ex(4, 0, 0, 0, 0, 1), "press_restart"};
        vecs[3]  = '{0, 0, 1, ex(1, 1, 0, 0, 0, 0), "restart_to_run"};
        vecs[4]  = '{1, 0, 0, ex(1, 1, 0, 0, 0, 0), "run_tick"};
        vecs[5]  = '{0, 0, 1, ex(1, 1, 0, 0, 0, 0), "run_btn_ignored"};
        vecs[6]  = '{1, 1, 0, ex(2, 0, 1, 0, 0, 0), "tick_plus_collision_hit"};
        vecs[7]  = '{1, 0, 0, ex(2, 0, 1, 0, 0, 0), "hit_cnt1"};
        vecs[8]  = '{1, 0, 0, ex(2, 0, 1, 0, 0, 0), "hit_cnt2"};
        vecs[9]  = '{1, 0, 0, ex(2, 0, 1, 0, 0, 0), "hit_cnt3"};
        vecs[10] = '{1, 0, 0, ex(2, 0, 1, 1, 0, 0), "hit_cnt4_flash"};
        vecs[11] = '{0, 0, 1, ex(2, 0, 1, 1, 0, 0), "hit_btn_ignored"};

        reset = 1'b1; frame_tick = 1'b0; collision = 1'b0; btn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_state", ex(0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].tick, vecs[i].col, vecs[i].b);
            chk(vecs[i].name, vecs[i].exp);
        end

        // Finish the hit window: 4 ticks done, 25 more reach cnt=29.
        for (int k = 0; k < 25; k++) do_tick(1'b0);
        chk("hit_cnt29", ex(2, 0, 1, 1, 0, 0));
        do_tick(1'b0);
        chk("hit_to_over", ex(3, 0, 1, 0, 1, 0));

        // Overlay blink: toggles after ticks 20, 40, 60.
        toggles = 0;
        prev_ov = overlay_en;
        for (int k = 1; k <= 60; k++) begin
            do_tick(1'b0);
            if (overlay_en !== prev_ov) toggles++;
            prev_ov = overlay_en;
            if (k % 10 == 0 || k % 20 == 19)
                chk($sformatf("blink_k%0d", k), ex(3, 0, 1, 0, ((k / 20) % 2) == 0, 0));
        end
        chk_int("blink_toggle_count", toggles, 3);

        step(1'b0, 1'b1, 1'b0);
        chk("over_collision_ignored", ex(3, 0, 1, 0, 0, 0));
        step(1'b0, 1'b0, 1'b1);
        chk("over_armed_press", ex(4, 0, 0, 0, 0, 1));
        step(1'b0, 1'b0, 1'b0);
        chk("over_restart_to_run", ex(1, 1, 0, 0, 0, 0));

        // Button held from RUN into OVER; lockout must hold off every press.
        step(1'b0, 1'b1, 1'b1);
        chk("held_hit", ex(2, 0, 1, 0, 0, 0));
        for (int k = 0; k < 30; k++) do_tick(1'b1);
        chk("held_over_entry", ex(3, 0, 1, 0, 1, 0));
        rs_base = restart_seen;
        for (int k = 0; k < 10; k++) do_tick(1'b1);
        for (int k = 0; k < 19; k++) do_tick(1'b0);
        for (int k = 0; k < 32; k++) do_tick(1'b1);
        chk("lockout_press_t30", ex(3, 0, 1, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0);
        chk("lockout_release_t61", ex(3, 0, 1, 0, 0, 0));
        chk_int("lockout_no_restart", restart_seen - rs_base, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("lockout_repress", ex(4, 0, 0, 0, 0, 1));
        step(1'b0, 1'b0, 1'b0);
        chk("lockout_run", ex(1, 1, 0, 0, 0, 0));

        // Reset mid-HIT at cnt=15 must clear outputs without a clock edge.
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) do_tick(1'b0);
        chk("hit_cnt15", ex(2, 0, 1, 1, 0, 0));
        btn = 1'b1;
        #2 reset = 1'b1;
        #1 chk("async_reset_mid_hit", ex(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Button held through reset release is not a press.
        rs_base = restart_seen;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("held_through_reset", ex(0, 0, 0, 0, 0, 0));
        chk_int("held_through_reset_no_rs", restart_seen - rs_base, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("press_after_reset", ex(4, 0, 0, 0, 0, 1));
        step(1'b0, 1'b0, 1'b0);
        chk("run_after_reset", ex(1, 1, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
